// File: rtl/game_round_ctrl.sv
// ============================================================================
//  Module      : game_round_ctrl
//  Description : Round controller for the binary-conversion game. It draws a
//                target, grades the player's answer, and tracks the streak
//                score and high score.
//  Revision    : 1.0  initial parametrised release
// ============================================================================
`default_nettype none

module game_round_ctrl #(
    parameter int WIDTH         = 8,
    parameter int SCORE_W       = 8,
    parameter int MIN_SHOW      = 10,
    parameter int WAIT_TICKS    = 10,
    parameter int TIMEOUT_TICKS = 0,
    parameter int NO_REPEAT     = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tick,
    input  logic               enter,
    input  logic [WIDTH-1:0]   sw,
    input  logic [WIDTH-1:0]   rand_in,
    output logic [WIDTH-1:0]   disp_val,
    output logic [2:0]         msg_sel,
    output logic [WIDTH-1:0]   led_mask,
    output logic [SCORE_W-1:0] score,
    output logic [SCORE_W-1:0] high_score,
    output logic [2:0]         state
);

    localparam int c_TMAX_A = (MIN_SHOW > WAIT_TICKS) ? MIN_SHOW : WAIT_TICKS;
    localparam int c_TMAX   = (c_TMAX_A > TIMEOUT_TICKS) ? c_TMAX_A : TIMEOUT_TICKS;
    // One spare code above the largest threshold so saturation never masks a compare.
    localparam int c_TW     = $clog2(c_TMAX + 2);

    localparam logic [2:0] c_MSG_NUM     = 3'd0;
    localparam logic [2:0] c_MSG_GOOD    = 3'd1;
    localparam logic [2:0] c_MSG_FAIL    = 3'd2;
    localparam logic [2:0] c_MSG_SCORE   = 3'd3;
    localparam logic [2:0] c_MSG_TIMEOUT = 3'd4;

    typedef enum logic [2:0] {
        S_LOAD  = 3'd0,
        S_SHOW  = 3'd1,
        S_GOOD  = 3'd2,
        S_FAIL  = 3'd3,
        S_SCORE = 3'd4
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [c_TW-1:0]     r_timer, w_timer_nxt;
    logic [WIDTH-1:0]    r_target, w_target_nxt;
    logic [WIDTH-1:0]    r_prev, w_prev_nxt;
    logic                r_enter_q;
    logic [WIDTH-1:0]    w_disp_nxt, w_led_nxt;
    logic [2:0]          w_msg_nxt;
    logic [SCORE_W-1:0]  w_score_nxt, w_high_nxt, w_score_inc;
    logic                w_press, w_accept, w_repeat, w_timeout, w_hold_done;

    assign w_press     = enter & ~r_enter_q;
    assign w_accept    = w_press && (r_timer >= c_TW'(MIN_SHOW));
    assign w_hold_done = (r_timer == c_TW'(WAIT_TICKS));
    assign w_score_inc = (&score) ? score : score + 1'b1;
    assign state       = r_state;

    generate
        if (NO_REPEAT != 0) begin : g_no_repeat
            assign w_repeat = (rand_in == r_prev);
        end else begin : g_allow_repeat
            assign w_repeat = 1'b0;
        end
    endgenerate

    generate
        if (TIMEOUT_TICKS != 0) begin : g_timeout
            assign w_timeout = (r_timer == c_TW'(TIMEOUT_TICKS));
        end else begin : g_no_timeout
            assign w_timeout = 1'b0;
        end
    endgenerate

    always_comb begin
        w_state_nxt  = r_state;
        w_target_nxt = r_target;
        w_prev_nxt   = r_prev;
        w_disp_nxt   = disp_val;
        w_msg_nxt    = msg_sel;
        w_led_nxt    = led_mask;
        w_score_nxt  = score;
        w_high_nxt   = high_score;
        w_timer_nxt  = (tick && !(&r_timer)) ? r_timer + 1'b1 : r_timer;

        case (r_state)
            S_LOAD: begin
                w_target_nxt = rand_in;
                w_led_nxt    = '0;
                w_timer_nxt  = '0;
                if (!w_repeat) begin
                    w_prev_nxt  = rand_in;
                    w_disp_nxt  = rand_in;
                    w_msg_nxt   = c_MSG_NUM;
                    w_state_nxt = S_SHOW;
                end
            end
            S_SHOW: begin
                // A press always wins over a simultaneous timeout.
                if (w_accept) begin
                    if (sw == r_target) begin
                        w_score_nxt = w_score_inc;
                        w_high_nxt  = (w_score_inc > high_score) ? w_score_inc : high_score;
                        w_msg_nxt   = c_MSG_GOOD;
                        w_state_nxt = S_GOOD;
                    end else begin
                        w_disp_nxt  = sw;
                        w_led_nxt   = r_target;
                        w_score_nxt = '0;
                        w_msg_nxt   = c_MSG_FAIL;
                        w_state_nxt = S_FAIL;
                    end
                end else if (w_timeout) begin
                    w_disp_nxt  = r_target;
                    w_led_nxt   = r_target;
                    w_score_nxt = '0;
                    w_msg_nxt   = c_MSG_TIMEOUT;
                    w_state_nxt = S_FAIL;
                end
            end
            S_GOOD, S_FAIL: begin
                if (w_hold_done) begin
                    w_disp_nxt  = WIDTH'(score);
                    w_msg_nxt   = c_MSG_SCORE;
                    w_state_nxt = S_SCORE;
                end
            end
            S_SCORE: begin
                if (w_hold_done) begin
                    w_led_nxt   = '0;
                    w_msg_nxt   = c_MSG_NUM;
                    w_state_nxt = S_LOAD;
                end
            end
            default: begin
                w_state_nxt = S_LOAD;
            end
        endcase

        if (w_state_nxt != r_state) begin
            w_timer_nxt = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_LOAD;
            r_timer    <= '0;
            r_target   <= '0;
            r_prev     <= '0;
            r_enter_q  <= 1'b0;
            disp_val   <= '0;
            msg_sel    <= '0;
            led_mask   <= '0;
            score      <= '0;
            high_score <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_timer    <= w_timer_nxt;
            r_target   <= w_target_nxt;
            r_prev     <= w_prev_nxt;
            r_enter_q  <= enter;
            disp_val   <= w_disp_nxt;
            msg_sel    <= w_msg_nxt;
            led_mask   <= w_led_nxt;
            score      <= w_score_nxt;
            high_score <= w_high_nxt;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_game_round_ctrl.sv
// ============================================================================
//  Module      : tb_game_round_ctrl
//  Description : Self-checking bench for game_round_ctrl; expected state-change
//                snapshots are queued by the stimulus and popped by a monitor.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_game_round_ctrl;

    localparam logic [2:0] ST_LOAD = 3'd0, ST_SHOW = 3'd1, ST_GOOD = 3'd2,
                           ST_FAIL = 3'd3, ST_SCORE = 3'd4;
    localparam logic [2:0] M_NUM = 3'd0, M_GOOD = 3'd1, M_FAIL = 3'd2,
                           M_SCORE = 3'd3, M_TMO = 3'd4;

    logic       clk = 1'b0;
    logic       rst, tick, enter;
    logic [7:0] sw, rand_in;
    logic [7:0] disp_val, led_mask, score, high_score;
    logic [2:0] msg_sel, state;

    int         checks = 0, failures = 0;
    int         n_ticks = 0, base = 0, tick_per = 4;
    logic [7:0] es = 8'h00, eh = 8'h00;
    logic [37:0] exp_q[$];

    always #5 clk = ~clk;

    game_round_ctrl #(
        .WIDTH(8), .SCORE_W(8), .MIN_SHOW(10), .WAIT_TICKS(10),
        .TIMEOUT_TICKS(20), .NO_REPEAT(1)
    ) dut (
        .clk(clk), .rst(rst), .tick(tick), .enter(enter), .sw(sw),
        .rand_in(rand_in), .disp_val(disp_val), .msg_sel(msg_sel),
        .led_mask(led_mask), .score(score), .high_score(high_score),
        .state(state)
    );

    function automatic logic [37:0] snap_now();
        return {state, msg_sel, disp_val, led_mask, score, high_score};
    endfunction

    task automatic check(input string name, input logic [37:0] got, input logic [37:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic push(input logic [2:0] st, input logic [2:0] m, input logic [7:0] d,
                        input logic [7:0] l, input logic [7:0] s, input logic [7:0] h);
        exp_q.push_back({st, m, d, l, s, h});
    endtask

    task automatic wait_state(input logic [2:0] s);
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            if (state == s) return;
        end
        checks++; failures++;
        $display("FAIL wait_state got=%0d exp=%0d (timed out)", state, s);
    endtask

    // In this bench n_ticks-base tracks the DUT timer at every posedge+1.
    task automatic wait_timer(input int k);
        for (int i = 0; i < 3000; i++) begin
            if (n_ticks - base >= k) return;
            @(posedge clk); #1;
        end
        checks++; failures++;
        $display("FAIL wait_timer got=%0d exp=%0d (timed out)", n_ticks - base, k);
    endtask

    task automatic press(input logic [7:0] ans);
        sw = ans; enter = 1'b1;
        @(posedge clk); #1;
        enter = 1'b0;
    endtask

    task automatic start_round(input logic [7:0] tgt);
        rand_in = tgt;
        push(ST_SHOW, M_NUM, tgt, 8'h00, es, eh);
        wait_state(ST_SHOW);
        base = n_ticks;
    endtask

    task automatic expect_good(input logic [7:0] tgt);
        es = (es == 8'hFF) ? 8'hFF : es + 8'h01;
        if (es > eh) eh = es;
        push(ST_GOOD, M_GOOD, tgt, 8'h00, es, eh);
    endtask

    task automatic finish_round(input logic [7:0] led);
        push(ST_SCORE, M_SCORE, es, led, es, eh);
        push(ST_LOAD, M_NUM, es, 8'h00, es, eh);
        wait_state(ST_LOAD);
    endtask

    initial begin : g_tick_gen
        int ph;
        ph = 0;
        tick = 1'b0;
        forever begin
            @(negedge clk);
            if (tick_per <= 1) begin
                tick = 1'b1;
            end else begin
                tick = (ph == 0);
                ph = (ph + 1) % tick_per;
            end
            if (tick) n_ticks++;
        end
    end

    initial begin : g_monitor
        logic [2:0]  prev_st;
        logic [37:0] e;
        prev_st = ST_LOAD;
        forever begin
            @(negedge clk);
            if (state !== prev_st) begin
                prev_st = state;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_event got=%h exp=none", snap_now());
                end else begin
                    e = exp_q.pop_front();
                    if (snap_now() !== e) begin
                        failures++;
                        $display("FAIL event got=%h exp=%h", snap_now(), e);
                    end
                end
            end
        end
    end

    initial begin : g_watchdog
        #400000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        rst = 1'b1; enter = 1'b0; sw = 8'h00; rand_in = 8'h5A;
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", snap_now(), 38'h0);

        // Correct answer; a press one tick early is ignored.
        push(ST_SHOW, M_NUM, 8'h5A, 8'h00, 8'h00, 8'h00);
        rst = 1'b0;
        wait_state(ST_SHOW);
        base = n_ticks;
        wait_timer(9);
        press(8'h5A);
        @(posedge clk); #1;
        check("early_press_ignored", {35'h0, state}, {35'h0, ST_SHOW});
        wait_timer(10);
        expect_good(8'h5A);
        press(8'h5A);
        check("press_latency", {35'h0, state}, {35'h0, ST_GOOD});
        finish_round(8'h00);

        // Same draw as the previous target keeps LOAD.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("no_repeat_hold", {35'h0, state}, {35'h0, ST_LOAD});
        end

        // Early held press is discarded; a fresh rise grades once.
        start_round(8'h33);
        wait_timer(3);
        sw = 8'h33; enter = 1'b1;
        repeat (50) @(posedge clk);
        #1;
        check("held_no_grade", {35'h0, state}, {35'h0, ST_SHOW});
        enter = 1'b0;
        @(posedge clk); #1;
        expect_good(8'h33);
        enter = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        enter = 1'b0;
        finish_round(8'h00);

        // Wrong answer and hold timing of FAIL and SCORE.
        start_round(8'h5A);
        wait_timer(10);
        es = 8'h00;
        push(ST_FAIL, M_FAIL, 8'h12, 8'h5A, es, eh);
        push(ST_SCORE, M_SCORE, 8'h00, 8'h5A, es, eh);
        push(ST_LOAD, M_NUM, 8'h00, 8'h00, es, eh);
        press(8'h12);
        base = n_ticks;
        wait_timer(10);
        check("fail_hold", {35'h0, state}, {35'h0, ST_FAIL});
        @(posedge clk); #1;
        check("fail_to_score", {35'h0, state}, {35'h0, ST_SCORE});
        base = n_ticks;
        wait_timer(10);
        check("score_hold", {35'h0, state}, {35'h0, ST_SCORE});
        @(posedge clk); #1;
        check("score_to_load", {35'h0, state}, {35'h0, ST_LOAD});

        // Timeout with no press.
        start_round(8'h77);
        wait_timer(20);
        check("pre_timeout", {35'h0, state}, {35'h0, ST_SHOW});
        push(ST_FAIL, M_TMO, 8'h77, 8'h77, 8'h00, eh);
        @(posedge clk); #1;
        check("timeout_msg", {35'h0, msg_sel}, {35'h0, M_TMO});
        finish_round(8'h77);

        // Press on the timeout clk is graded.
        start_round(8'h21);
        wait_timer(20);
        expect_good(8'h21);
        press(8'h21);
        finish_round(8'h00);

        // Drive the score to saturation.
        tick_per = 1;
        for (int i = 0; i < 255; i++) begin
            start_round((i % 2 == 0) ? 8'h10 : 8'h11);
            wait_timer(10);
            expect_good((i % 2 == 0) ? 8'h10 : 8'h11);
            press((i % 2 == 0) ? 8'h10 : 8'h11);
            finish_round(8'h00);
        end
        check("score_saturated", {22'h0, score, high_score}, {22'h0, 8'hFF, 8'hFF});

        // Asynchronous reset in the middle of a GOOD hold.
        start_round(8'h5A);
        wait_timer(10);
        expect_good(8'h5A);
        press(8'h5A);
        repeat (3) @(posedge clk);
        #2;
        push(ST_LOAD, M_NUM, 8'h00, 8'h00, 8'h00, 8'h00);
        rst = 1'b1;
        #1;
        check("async_reset", snap_now(), 38'h0);
        es = 8'h00; eh = 8'h00;
        @(posedge clk); #1;
        rst = 1'b0;
        start_round(8'h5A);

        repeat (5) @(posedge clk);
        #1;
        check("queue_drained", 38'(exp_q.size()), 38'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
